// File: rtl/div_pkg.sv
// Shared types and constants for the multi-cycle radix-2 restoring divider.
// Imported by the sequencer (div_unit) and the per-iteration datapath (div_step).
package div_pkg;

  localparam int DIV_WIDTH  = 32;
  localparam int DIV_CYCLES = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } div_state_t;

endpackage

// File: rtl/div_step.sv
// One restoring-division iteration on magnitudes, purely combinational (zero latency).
// No flow control: the sequencer applies it once per BUSY cycle.
module div_step
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic [WIDTH-1:0] rem_i,
  input  logic [WIDTH-1:0] quo_i,
  input  logic [WIDTH-1:0] divisor_i,
  output logic [WIDTH-1:0] rem_o,
  output logic [WIDTH-1:0] quo_o
);

  logic [WIDTH:0]   rem_sh;
  logic [WIDTH-1:0] diff;
  logic             fits;

  always_comb begin
    rem_sh = {rem_i, quo_i[WIDTH-1]};
    fits   = (rem_sh >= {1'b0, divisor_i});
    // When the divisor fits, the true difference is below 2^WIDTH, so the
    // truncated subtraction is exact and the carry bit can be ignored.
    diff   = rem_sh[WIDTH-1:0] - divisor_i;
    rem_o  = rem_sh[WIDTH-1:0];
    quo_o  = {quo_i[WIDTH-2:0], 1'b0};
    if (fits) begin
      rem_o    = diff;
      quo_o[0] = 1'b1;
    end
  end

endmodule

// File: rtl/div_unit.sv
// DIV/DIVU sequencer: stall_o rises combinationally with start, ready_o pulses DIV_CYCLES+1 cycles later.
// annul_i aborts at the next edge; start_i held through DONE never restarts the divider.
module div_unit
  import div_pkg::*;
#(
  parameter int WIDTH      = DIV_WIDTH,
  parameter int DIV_CYCLES = WIDTH
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic               start_i,
  input  logic               signed_i,
  input  logic               annul_i,
  input  logic [WIDTH-1:0]   a_i,
  input  logic [WIDTH-1:0]   b_i,
  output logic               stall_o,
  output logic               ready_o,
  output logic [2*WIDTH-1:0] result_o
);

  localparam int CNT_W = $clog2(DIV_CYCLES + 1);

  div_state_t         state_q, state_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic [WIDTH-1:0]   rem_q, rem_d;
  logic [WIDTH-1:0]   quo_q, quo_d;
  logic [WIDTH-1:0]   dvsr_q, dvsr_d;
  logic               a_sign_q, a_sign_d;
  logic               b_sign_q, b_sign_d;
  logic               signed_q, signed_d;
  logic [2*WIDTH-1:0] result_q, result_d;

  logic [WIDTH-1:0]   a_mag, b_mag;
  logic [WIDTH-1:0]   step_rem, step_quo;
  logic [WIDTH-1:0]   q_fix, r_fix;
  logic               neg_quo, neg_rem, last_step;

  div_step #(.WIDTH(WIDTH)) u_step (
    .rem_i     (rem_q),
    .quo_i     (quo_q),
    .divisor_i (dvsr_q),
    .rem_o     (step_rem),
    .quo_o     (step_quo)
  );

  always_comb begin
    a_mag     = (signed_i && a_i[WIDTH-1]) ? -a_i : a_i;
    b_mag     = (signed_i && b_i[WIDTH-1]) ? -b_i : b_i;
    // Remainder follows the dividend's sign; quotient is negative on sign mismatch.
    neg_quo   = signed_q && (a_sign_q ^ b_sign_q);
    neg_rem   = signed_q && a_sign_q;
    q_fix     = neg_quo ? -step_quo : step_quo;
    r_fix     = neg_rem ? -step_rem : step_rem;
    last_step = (count_q == CNT_W'(DIV_CYCLES - 1));
  end

  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    rem_d    = rem_q;
    quo_d    = quo_q;
    dvsr_d   = dvsr_q;
    a_sign_d = a_sign_q;
    b_sign_d = b_sign_q;
    signed_d = signed_q;
    result_d = result_q;
    stall_o  = 1'b0;
    ready_o  = 1'b0;

    if (annul_i) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          stall_o = start_i;
          if (start_i) begin
            quo_d    = a_mag;
            dvsr_d   = b_mag;
            rem_d    = '0;
            count_d  = '0;
            a_sign_d = a_i[WIDTH-1];
            b_sign_d = b_i[WIDTH-1];
            signed_d = signed_i;
            state_d  = BUSY;
          end
        end
        BUSY: begin
          stall_o = 1'b1;
          rem_d   = step_rem;
          quo_d   = step_quo;
          count_d = count_q + CNT_W'(1);
          if (last_step) begin
            result_d = {r_fix, q_fix};
            state_d  = DONE;
          end
        end
        DONE: begin
          ready_o = 1'b1;
          state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q  <= IDLE;
      count_q  <= '0;
      rem_q    <= '0;
      quo_q    <= '0;
      dvsr_q   <= '0;
      a_sign_q <= 1'b0;
      b_sign_q <= 1'b0;
      signed_q <= 1'b0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      rem_q    <= rem_d;
      quo_q    <= quo_d;
      dvsr_q   <= dvsr_d;
      a_sign_q <= a_sign_d;
      b_sign_q <= b_sign_d;
      signed_q <= signed_d;
      result_q <= result_d;
    end
  end

  assign result_o = result_q;

endmodule

// File: tb/tb_div_unit.sv
// Self-checking bench for div_unit: arithmetic reference plus a cycle timeline model,
// compared every cycle, with directed corner cases and randomized operations.
module tb_div_unit;
  localparam int W   = 32;
  localparam int CYC = 32;

  logic          clk = 1'b0;
  logic          resetn = 1'b0;
  logic          start_i = 1'b0;
  logic          signed_i = 1'b0;
  logic          annul_i = 1'b0;
  logic [W-1:0]  a_i = '0;
  logic [W-1:0]  b_i = '0;
  logic          stall_o;
  logic          ready_o;
  logic [2*W-1:0] result_o;

  div_unit #(.WIDTH(W), .DIV_CYCLES(CYC)) dut (
    .clk      (clk),
    .resetn   (resetn),
    .start_i  (start_i),
    .signed_i (signed_i),
    .annul_i  (annul_i),
    .a_i      (a_i),
    .b_i      (b_i),
    .stall_o  (stall_o),
    .ready_o  (ready_o),
    .result_o (result_o)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  int ready_cnt = 0;
  logic chk_en = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%016h expected 0x%016h at %0t", name, act, exp, $time);
  endtask

  // MIPS semantics from plain arithmetic; 64-bit math keeps the signed overflow case exact.
  function automatic logic [63:0] ref_div(input logic [31:0] a, input logic [31:0] b, input logic s);
    longint sa, sb, q, r;
    if (!s) begin
      if (b == 0) return {a, 32'hFFFF_FFFF};
      return {a % b, a / b};
    end
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    if (b == 0) return {a, (sa < 0) ? 32'd1 : 32'hFFFF_FFFF};
    q = sa / sb;
    r = sa % sb;
    return {r[31:0], q[31:0]};
  endfunction

  // Timeline model: an accepted start yields ready exactly CYC+1 cycles later.
  logic        m_busy = 1'b0;
  logic        m_done = 1'b0;
  int          m_left = 0;
  logic [63:0] m_pending = '0;
  logic [63:0] m_result = '0;

  always @(posedge clk) begin
    if (!resetn) begin
      m_busy <= 1'b0; m_done <= 1'b0; m_left <= 0; m_result <= '0;
    end else if (annul_i) begin
      m_busy <= 1'b0; m_done <= 1'b0;
    end else if (m_done) begin
      m_done <= 1'b0;
    end else if (m_busy) begin
      m_left <= m_left - 1;
      if (m_left == 1) begin
        m_busy <= 1'b0; m_done <= 1'b1; m_result <= m_pending;
      end
    end else if (start_i) begin
      m_busy <= 1'b1; m_left <= CYC; m_pending <= ref_div(a_i, b_i, signed_i);
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("stall_o", {63'd0, stall_o}, {63'd0, m_busy ? !annul_i : (!m_done && start_i && !annul_i)});
      chk("ready_o", {63'd0, ready_o}, {63'd0, m_done && !annul_i});
      chk("result_o", result_o, m_result);
      if (ready_o) ready_cnt++;
    end
  end

  // Drives one instruction from posedge+1; start stays high through DONE, operands
  // are scrambled after the start edge. annul_at = cycle offset to annul, or -1.
  task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic s,
                        input int annul_at, output logic [63:0] res, output logic got,
                        output int stalls);
    logic stop;
    start_i = 1'b1; signed_i = s; a_i = a; b_i = b;
    got = 1'b0; stalls = 0; res = '0; stop = 1'b0;
    for (int c = 0; c < 60 && !got && !stop; c++) begin
      if (c == annul_at) annul_i = 1'b1;
      @(negedge clk);
      if (stall_o) stalls++;
      if (ready_o) begin got = 1'b1; res = result_o; end
      @(posedge clk); #1;
      if (annul_i) begin annul_i = 1'b0; stop = 1'b1; end
      if (c == 0) begin a_i = $urandom; b_i = $urandom; signed_i = $urandom_range(0, 1); end
    end
    start_i = 1'b0;
  endtask

  function automatic logic [31:0] pick_op();
    case ($urandom_range(0, 5))
      0: return 32'd0;
      1: return 32'h8000_0000;
      2: return 32'hFFFF_FFFF;
      3: return ($urandom_range(0, 1) != 0) ? -32'($urandom_range(1, 20)) : 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    logic [63:0] res, prev;
    logic got;
    int stalls, r0;

    chk("pin_divu", ref_div(32'd100, 32'd7, 1'b0), {32'd2, 32'd14});
    chk("pin_div_neg", ref_div(32'hFFFF_FFF9, 32'd2, 1'b1), {32'hFFFF_FFFF, 32'hFFFF_FFFD});
    chk("pin_div_ovf", ref_div(32'h8000_0000, 32'hFFFF_FFFF, 1'b1), {32'd0, 32'h8000_0000});
    chk("pin_div0_s", ref_div(32'hFFFF_FFFB, 32'd0, 1'b1), {32'hFFFF_FFFB, 32'd1});

    repeat (2) @(posedge clk);
    #1 chk_en = 1'b1;
    @(negedge clk);
    chk("rst_result", result_o, 64'd0);
    chk("rst_stall", {63'd0, stall_o}, 64'd0);
    @(posedge clk); #1 resetn = 1'b1;
    @(posedge clk); #1;

    run_op(32'd100, 32'd7, 1'b0, -1, res, got, stalls);
    chk("divu_100_7_done", {63'd0, got}, 64'd1);
    chk("divu_100_7_stall", 64'(stalls), 64'd33);
    chk("divu_100_7", res, {32'd2, 32'd14});

    run_op(32'hFFFF_FFF9, 32'd2, 1'b1, -1, res, got, stalls);
    chk("div_m7_2", res, {32'hFFFF_FFFF, 32'hFFFF_FFFD});
    run_op(32'd7, 32'hFFFF_FFFE, 1'b1, -1, res, got, stalls);
    chk("div_7_m2", res, {32'd1, 32'hFFFF_FFFD});
    run_op(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, -1, res, got, stalls);
    chk("div_ovf", res, {32'd0, 32'h8000_0000});
    chk("div_ovf_stall", 64'(stalls), 64'd33);
    run_op(32'd5, 32'd0, 1'b0, -1, res, got, stalls);
    chk("divu_5_0", res, {32'd5, 32'hFFFF_FFFF});
    chk("divu_5_0_stall", 64'(stalls), 64'd33);

    // Back-to-back: second instruction enters E right after the DONE cycle.
    r0 = ready_cnt;
    run_op(32'd20, 32'd6, 1'b0, -1, res, got, stalls);
    chk("b2b_first", res, {32'd2, 32'd3});
    run_op(32'd9, 32'd3, 1'b0, -1, res, got, stalls);
    chk("b2b_second", res, {32'd0, 32'd3});
    chk("b2b_second_stall", 64'(stalls), 64'd33);
    chk("b2b_ready_count", 64'(ready_cnt - r0), 64'd2);

    // Annul at BUSY cycle 10.
    prev = result_o;
    r0 = ready_cnt;
    run_op(32'd100, 32'd7, 1'b0, 10, res, got, stalls);
    chk("annul_no_ready", {63'd0, got}, 64'd0);
    @(negedge clk);
    chk("annul_idle_stall", {63'd0, stall_o}, 64'd0);
    chk("annul_result_held", result_o, prev);
    chk("annul_ready_count", 64'(ready_cnt - r0), 64'd0);
    @(posedge clk); #1;
    run_op(32'd8, 32'd2, 1'b0, -1, res, got, stalls);
    chk("after_annul_8_2", res, {32'd0, 32'd4});

    // Synchronous reset at BUSY cycle 5.
    start_i = 1'b1; signed_i = 1'b0; a_i = 32'd77; b_i = 32'd3;
    for (int c = 0; c < 6; c++) begin
      if (c == 5) begin resetn = 1'b0; start_i = 1'b0; end
      @(posedge clk); #1;
    end
    resetn = 1'b1;
    @(negedge clk);
    chk("mid_rst_stall", {63'd0, stall_o}, 64'd0);
    chk("mid_rst_ready", {63'd0, ready_o}, 64'd0);
    chk("mid_rst_result", result_o, 64'd0);
    @(posedge clk); #1;

    for (int i = 0; i < 60; i++) begin
      logic [31:0] ra, rb;
      logic rs;
      int an;
      ra = pick_op();
      rb = pick_op();
      rs = 1'($urandom_range(0, 1));
      an = ($urandom_range(0, 9) == 0) ? int'($urandom_range(1, CYC + 1)) : -1;
      run_op(ra, rb, rs, an, res, got, stalls);
      if (an < 0) begin
        chk("rand_done", {63'd0, got}, 64'd1);
        chk("rand_result", res, ref_div(ra, rb, rs));
      end
      repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
    end

    repeat (2) @(posedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
